// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter (serializer, parity generator and frame FSM in one block)
// Ports: clk (bit-rate clock), RST (async active-high reset), P_DATA/Data_Valid/DATA_READY (payload handshake),
//        PAR_EN/PAR_TYP/STOP_2 (frame config, sampled on acceptance), TX_OUT (registered serial line), busy (frame in progress).
// Define UART_TX_HOLD_REG_EN to add a 1-entry holding register for back-to-back frames.
module uart_tx_param #(
  parameter int DATA_WIDTH = 8,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP_2,
  output logic                  DATA_READY,
  output logic                  TX_OUT,
  output logic                  busy
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [2:0] IDLE = 3'b000, START = 3'b001, DATA = 3'b011, PARITY = 3'b010, STOP1 = 3'b110, STOP2 = 3'b111;
  logic [2:0] state, nxt;
  logic [DATA_WIDTH-1:0] sr, ld_data;
  logic [CW-1:0] cnt;
  logic pen_q, par_q, stop2_q, tx_nxt, accept, last_bit, last_stop, load, ld_pen, ld_par, ld_stop2;
  assign busy = state != IDLE;
  assign accept = Data_Valid & DATA_READY;
  assign last_bit = state == DATA && cnt == CW'(DATA_WIDTH - 1);
  assign last_stop = (state == STOP1 && !stop2_q) || state == STOP2;
`ifdef UART_TX_HOLD_REG_EN
  logic hold_full, hold_pen, hold_par, hold_stop2;
  logic [DATA_WIDTH-1:0] hold_data;
  assign DATA_READY = ~hold_full;
  // a held payload starts as soon as the line is free: from IDLE or straight out of the last stop bit
  assign load = hold_full ? (!busy || last_stop) : (accept && !busy);
  assign ld_data = hold_full ? hold_data : P_DATA;
  assign ld_pen = hold_full ? hold_pen : PAR_EN;
  assign ld_par = hold_full ? hold_par : ^P_DATA ^ PAR_TYP;
  assign ld_stop2 = hold_full ? hold_stop2 : STOP_2;
  always_ff @(posedge clk or posedge RST)
    if (RST) begin
      hold_full <= 1'b0;
      hold_data <= '0;
      hold_pen <= 1'b0;
      hold_par <= 1'b0;
      hold_stop2 <= 1'b0;
    end else if (accept && busy) begin
      hold_full <= 1'b1;
      hold_data <= P_DATA;
      hold_pen <= PAR_EN;
      hold_par <= ^P_DATA ^ PAR_TYP;
      hold_stop2 <= STOP_2;
    end else if (load && hold_full) hold_full <= 1'b0;
`else
  assign DATA_READY = ~busy;
  assign load = accept;
  assign ld_data = P_DATA;
  assign ld_pen = PAR_EN;
  assign ld_par = ^P_DATA ^ PAR_TYP;
  assign ld_stop2 = STOP_2;
`endif
  always_ff @(posedge clk or posedge RST)
    if (RST) begin
      state <= IDLE;
      TX_OUT <= IDLE_LEVEL;
    end else begin
      state <= nxt;
      TX_OUT <= tx_nxt;
    end
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = load ? START : IDLE;
      START:   nxt = DATA;
      DATA:    nxt = !last_bit ? DATA : pen_q ? PARITY : STOP1;
      PARITY:  nxt = STOP1;
      STOP1:   nxt = stop2_q ? STOP2 : load ? START : IDLE;
      STOP2:   nxt = load ? START : IDLE;
      default: nxt = IDLE;
    endcase
  end
  // line value for the cycle after this edge; sr[0] is the next data bit since sr shifts on the same edge
  always_comb tx_nxt = nxt == START ? ~IDLE_LEVEL : nxt == DATA ? sr[0] : nxt == PARITY ? par_q : IDLE_LEVEL;
  always_ff @(posedge clk or posedge RST)
    if (RST) begin
      sr <= '0;
      cnt <= '0;
      pen_q <= 1'b0;
      par_q <= 1'b0;
      stop2_q <= 1'b0;
    end else begin
      cnt <= state == DATA ? cnt + 1'b1 : '0;
      if (load) begin
        sr <= ld_data;
        pen_q <= ld_pen;
        par_q <= ld_par;
        stop2_q <= ld_stop2;
      end else if (nxt == DATA) sr <= sr >> 1;
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: randomized and directed self-checking bench for uart_tx_param against a frame-level model
module tb_uart_tx_param;
  localparam int DW = 8;
`ifdef UART_TX_HOLD_REG_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  logic clk = 1'b0, RST = 1'b1, Data_Valid = 1'b0, PAR_EN = 1'b0, PAR_TYP = 1'b0, STOP_2 = 1'b0;
  logic [DW-1:0] P_DATA = '0;
  logic DATA_READY, TX_OUT, busy;
  int vectors = 0, miscompares = 0;
  bit exp_q[$];
  logic [31:0] cap;
  uart_tx_param #(.DATA_WIDTH(DW), .IDLE_LEVEL(1'b1)) dut (
    .clk(clk), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .STOP_2(STOP_2), .DATA_READY(DATA_READY), .TX_OUT(TX_OUT), .busy(busy)
  );
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // frame model: start bit, payload LSB first, optional parity making the ones count even/odd, stop bits
  task automatic add_frame(input logic [DW-1:0] d, input bit pen, input bit typ, input bit s2);
    exp_q.push_back(1'b0);
    for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
    if (pen) exp_q.push_back(bit'(($countones(d) % 2) ^ int'(typ)));
    exp_q.push_back(1'b1);
    if (s2) exp_q.push_back(1'b1);
  endtask
  task automatic start(input logic [DW-1:0] d, input bit pen, input bit typ, input bit s2);
    P_DATA = d; PAR_EN = pen; PAR_TYP = typ; STOP_2 = s2; Data_Valid = 1'b1;
    cap = '0;
    @(negedge clk);
  endtask
  // walk the expected line cycle by cycle; optionally offer another payload at cycle inj_at
  task automatic play(input int inj_at, input logic [DW-1:0] inj_d, input bit ip, input bit it, input bit is2,
                      input int lo_from, input int lo_to);
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("tx[%0d]", i), TX_OUT, exp_q[i]);
      chk($sformatf("busy[%0d]", i), busy, 1);
      chk($sformatf("ready[%0d]", i), DATA_READY, (i >= lo_from && i <= lo_to) ? 0 : 1);
      cap = (cap << 1) | 32'(TX_OUT);
      Data_Valid = (i == inj_at);
      if (i == inj_at) begin
        P_DATA = inj_d; PAR_EN = ip; PAR_TYP = it; STOP_2 = is2;
      end else begin
        P_DATA = DW'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom); STOP_2 = 1'($urandom);
      end
      @(negedge clk);
    end
    Data_Valid = 1'b0;
    chk("end_busy", busy, 0);
    chk("end_tx", TX_OUT, 1);
    chk("end_ready", DATA_READY, 1);
  endtask
  task automatic frame(input logic [DW-1:0] d, input bit pen, input bit typ, input bit s2);
    exp_q.delete();
    add_frame(d, pen, typ, s2);
    start(d, pen, typ, s2);
    play(-1, '0, 0, 0, 0, HOLD ? -1 : 0, HOLD ? -1 : exp_q.size() - 1);
  endtask
  initial begin
    logic [DW-1:0] d;
    bit p, t, s;
    repeat (2) @(negedge clk);
    chk("rst_tx", TX_OUT, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", DATA_READY, 1);
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_tx", TX_OUT, 1);
      chk("idle_busy", busy, 0);
      chk("idle_ready", DATA_READY, 1);
    end
    frame(8'hA5, 1, 0, 0);
    chk("a5_even_seq", cap, 32'b01010010101);
    frame(8'hA5, 1, 1, 0);
    chk("a5_odd_seq", cap, 32'b01010010111);
    frame(8'h3C, 0, 0, 1);
    chk("3c_2stop_seq", cap, 32'b00011110011);
`ifndef UART_TX_HOLD_REG_EN
    exp_q.delete();
    add_frame(8'h5A, 1, 0, 1);
    start(8'h5A, 1, 0, 1);
    play(4, 8'hFF, 0, 1, 0, 0, exp_q.size() - 1);
    chk("ignored_seq", cap, 32'b001011010011);
`else
    exp_q.delete();
    add_frame(8'h55, 1, 0, 0);
    add_frame(8'hAA, 0, 0, 1);
    start(8'h55, 1, 0, 0);
    play(3, 8'hAA, 0, 0, 1, 4, 10);
`endif
    for (int n = 0; n < 24; n++) begin
      d = DW'($urandom); p = 1'($urandom); t = 1'($urandom); s = 1'($urandom);
      frame(d, p, t, s);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk("gap_tx", TX_OUT, 1);
        chk("gap_busy", busy, 0);
      end
    end
    start(8'hC3, 1, 0, 0);
    Data_Valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_tx", TX_OUT, 0);
    #2 RST = 1'b1;
    #1;
    chk("async_rst_tx", TX_OUT, 1);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ready", DATA_READY, 1);
    @(negedge clk);
    RST = 1'b0;
    @(negedge clk);
    frame(8'h81, 1, 0, 0);
    chk("81_seq", cap, 32'b01000000101);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
